// File: rtl/frame_painter.sv
// frame_painter
//   Scans a pixel window column-major and streams one pixel per cycle to a
//   VGA-style pixel sink. Three job modes:
//     FULL     (0, also 3) whole screen; outline ring in border_colour,
//                          everything else in fill_colour
//     BORDER   (1)         play area grown by BORDER; only the outline ring
//                          is plotted (border_colour), interior steps are
//                          scanned with vga_plot=0
//     INTERIOR (2)         play area only, all in fill_colour
//   mode and both colours are latched when a job is accepted.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   start, mode         job request (sampled while waitrequest=0), job mode
//   border_colour,
//   fill_colour         outline / non-outline colour
//   vga_ready           sink ready; present only with FRAME_PAINTER_STALL_EN
//   waitrequest         busy from the accepting edge until back in IDLE
//   done                one-cycle completion pulse
//   vga_plot, vga_x,
//   vga_y, vga_colour   pixel stream (colour is 0 whenever plot is 0)
//
// Build option
//   FRAME_PAINTER_STALL_EN : adds vga_ready back-pressure; a plotted pixel is
//   held until vga_ready=1. Undefined: the sink is always ready.

module frame_painter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3,
    parameter int AREA_X0  = 32,
    parameter int AREA_Y0  = 12,
    parameter int AREA_W   = 96,
    parameter int AREA_H   = 96,
    parameter int BORDER   = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [COLOUR_W-1:0] border_colour,
    input  logic [COLOUR_W-1:0] fill_colour,
`ifdef FRAME_PAINTER_STALL_EN
    input  logic                vga_ready,
`endif
    output logic                waitrequest,
    output logic                done,
    output logic                vga_plot,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour
);

    // Elaboration-time parameter legality
    if (AREA_X0 < BORDER) begin : g_bad_x0
        $error("frame_painter: AREA_X0 must be >= BORDER");
    end
    if (AREA_Y0 < BORDER) begin : g_bad_y0
        $error("frame_painter: AREA_Y0 must be >= BORDER");
    end
    if (AREA_X0 + AREA_W + BORDER > SCREEN_W) begin : g_bad_xr
        $error("frame_painter: outlined area exceeds SCREEN_W");
    end
    if (AREA_Y0 + AREA_H + BORDER > SCREEN_H) begin : g_bad_yb
        $error("frame_painter: outlined area exceeds SCREEN_H");
    end
    if (SCREEN_W > 2**X_W) begin : g_bad_xw
        $error("frame_painter: SCREEN_W does not fit in X_W bits");
    end
    if (SCREEN_H > 2**Y_W) begin : g_bad_yw
        $error("frame_painter: SCREEN_H does not fit in Y_W bits");
    end

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_BORDER   = 2'd1;
    localparam logic [1:0] M_INTERIOR = 2'd2;

    // Window edges, precomputed so stepping uses only equality compares
    localparam logic [X_W-1:0] XS_MAX = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] YS_MAX = Y_W'(SCREEN_H - 1);
    localparam logic [X_W-1:0] XA_MIN = X_W'(AREA_X0);
    localparam logic [X_W-1:0] XA_MAX = X_W'(AREA_X0 + AREA_W - 1);
    localparam logic [Y_W-1:0] YA_MIN = Y_W'(AREA_Y0);
    localparam logic [Y_W-1:0] YA_MAX = Y_W'(AREA_Y0 + AREA_H - 1);
    localparam logic [X_W-1:0] XB_MIN = X_W'(AREA_X0 - BORDER);
    localparam logic [X_W-1:0] XB_MAX = X_W'(AREA_X0 + AREA_W + BORDER - 1);
    localparam logic [Y_W-1:0] YB_MIN = Y_W'(AREA_Y0 - BORDER);
    localparam logic [Y_W-1:0] YB_MAX = Y_W'(AREA_Y0 + AREA_H + BORDER - 1);

    logic [1:0]          state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [COLOUR_W-1:0] bc_q, bc_d;
    logic [COLOUR_W-1:0] fc_q, fc_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic                plot_q, plot_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                ready;
    logic                advance;
    logic                load_pix;
    logic [1:0]          cur_mode;
    logic [COLOUR_W-1:0] cur_bc;
    logic [COLOUR_W-1:0] cur_fc;
    logic [X_W-1:0]      win_x_min, win_x_max, nx;
    logic [Y_W-1:0]      win_y_min, win_y_max, ny;
    logic                in_outer, in_area, outline;

`ifdef FRAME_PAINTER_STALL_EN
    assign ready = vga_ready;
`else
    assign ready = 1'b1;
`endif

    // A pixel leaves the current position when it is consumed or when it
    // is a non-plotted BORDER-mode step.
    assign advance = !plot_q || ready;

    always_comb begin
        // In IDLE the job parameters come straight from the inputs so the
        // first pixel can be registered on the accepting edge.
        if (state_q == S_IDLE) begin
            cur_mode = mode;
            cur_bc   = border_colour;
            cur_fc   = fill_colour;
        end else begin
            cur_mode = mode_q;
            cur_bc   = bc_q;
            cur_fc   = fc_q;
        end

        case (cur_mode)
            M_BORDER: begin
                win_x_min = XB_MIN;
                win_x_max = XB_MAX;
                win_y_min = YB_MIN;
                win_y_max = YB_MAX;
            end
            M_INTERIOR: begin
                win_x_min = XA_MIN;
                win_x_max = XA_MAX;
                win_y_min = YA_MIN;
                win_y_max = YA_MAX;
            end
            default: begin
                win_x_min = '0;
                win_x_max = XS_MAX;
                win_y_min = '0;
                win_y_max = YS_MAX;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        bc_d     = bc_q;
        fc_d     = fc_q;
        x_d      = x_q;
        y_d      = y_q;
        plot_d   = plot_q;
        colour_d = colour_q;
        load_pix = 1'b0;
        nx       = x_q;
        ny       = y_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_SCAN;
                    mode_d   = mode;
                    bc_d     = border_colour;
                    fc_d     = fill_colour;
                    nx       = win_x_min;
                    ny       = win_y_min;
                    load_pix = 1'b1;
                end
            end
            S_SCAN: begin
                if (advance) begin
                    if (y_q == win_y_max) begin
                        if (x_q == win_x_max) begin
                            state_d  = S_DONE;
                            x_d      = '0;
                            y_d      = '0;
                            plot_d   = 1'b0;
                            colour_d = '0;
                        end else begin
                            nx       = x_q + 1'b1;
                            ny       = win_y_min;
                            load_pix = 1'b1;
                        end
                    end else begin
                        ny       = y_q + 1'b1;
                        load_pix = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                x_d      = '0;
                y_d      = '0;
                plot_d   = 1'b0;
                colour_d = '0;
            end
        endcase

        in_outer = (nx >= XB_MIN) && (nx <= XB_MAX) && (ny >= YB_MIN) && (ny <= YB_MAX);
        in_area  = (nx >= XA_MIN) && (nx <= XA_MAX) && (ny >= YA_MIN) && (ny <= YA_MAX);
        outline  = in_outer && !in_area;

        if (load_pix) begin
            x_d = nx;
            y_d = ny;
            case (cur_mode)
                M_BORDER: begin
                    plot_d   = outline;
                    colour_d = outline ? cur_bc : '0;
                end
                M_INTERIOR: begin
                    plot_d   = 1'b1;
                    colour_d = cur_fc;
                end
                default: begin
                    plot_d   = 1'b1;
                    colour_d = outline ? cur_bc : cur_fc;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= '0;
            bc_q     <= '0;
            fc_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            plot_q   <= 1'b0;
            colour_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            bc_q     <= bc_d;
            fc_q     <= fc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            plot_q   <= plot_d;
            colour_q <= colour_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign waitrequest = busy_q;
    assign done        = done_q;
    assign vga_plot    = plot_q;
    assign vga_x       = x_q;
    assign vga_y       = y_q;
    assign vga_colour  = colour_q;

endmodule

// File: tb/tb_frame_painter.sv
// Directed testbench for frame_painter at default parameters.
// Jobs are launched from the falling edge and all outputs are sampled on
// falling edges. The stall scenario runs only when FRAME_PAINTER_STALL_EN
// is defined for both bench and design.

module tb_frame_painter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [2:0] border_colour;
    logic [2:0] fill_colour;
`ifdef FRAME_PAINTER_STALL_EN
    logic       vga_ready;
`endif
    logic       waitrequest;
    logic       done;
    logic       vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    frame_painter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mode          (mode),
        .border_colour (border_colour),
        .fill_colour   (fill_colour),
`ifdef FRAME_PAINTER_STALL_EN
        .vga_ready     (vga_ready),
`endif
        .waitrequest   (waitrequest),
        .done          (done),
        .vga_plot      (vga_plot),
        .vga_x         (vga_x),
        .vga_y         (vga_y),
        .vga_colour    (vga_colour)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Per-job observations
    int   cnt [160][120];
    int   col [160][120];
    int   n_wr, n_plot, n_done, n_leak, n_distinct;
    int   first_x, first_y, last_x, last_y;
    int   done_px;                 // x*1000+y of the pixel just before done
    int   px_x [100];
    int   px_y [100];
    int   cyc;
    bit   finished;

    task automatic clear_obs();
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++) begin
                cnt[i][j] = 0;
                col[i][j] = 0;
            end
        for (int k = 0; k < 100; k++) begin
            px_x[k] = -1;
            px_y[k] = -1;
        end
        n_wr = 0; n_plot = 0; n_done = 0; n_leak = 0; n_distinct = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        done_px = -1; finished = 1'b0;
    endtask

    // Launches a job and observes it. poke_at: scan cycle at which a second
    // start (mode 2, colours 1) is pulsed; abort_at: return once that many
    // pixels were plotted; do_stall: drop vga_ready 3 cycles at (40,20).
    task automatic run_job(input logic [1:0] m, input logic [2:0] bc,
                           input logic [2:0] fc, input int poke_at,
                           input bit do_stall, input int abort_at);
        bit seen_busy;
        int tail;
        int prev_px;
        int stall_left;
        bit stall_used;
        seen_busy = 1'b0; tail = 0; prev_px = -1; stall_left = 0; stall_used = 1'b0;
        clear_obs();
        @(negedge clk);
        mode = m; border_colour = bc; fill_colour = fc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 30000 && tail < 10) begin
            if (waitrequest) begin
                n_wr++;
                seen_busy = 1'b1;
            end else if (seen_busy) begin
                tail++;
            end
            if (done) begin
                n_done++;
                done_px = prev_px;
            end
            if (!vga_plot && vga_colour != 3'd0) n_leak++;
            prev_px = -1;
            if (vga_plot) begin
                if (n_plot < 100) begin
                    px_x[n_plot] = int'(vga_x);
                    px_y[n_plot] = int'(vga_y);
                end
                if (first_x < 0) begin
                    first_x = int'(vga_x);
                    first_y = int'(vga_y);
                end
                last_x = int'(vga_x);
                last_y = int'(vga_y);
                prev_px = int'(vga_x) * 1000 + int'(vga_y);
                n_plot++;
                if (vga_x < 8'd160 && vga_y < 7'd120) begin
                    if (cnt[vga_x][vga_y] == 0) n_distinct++;
                    cnt[vga_x][vga_y]++;
                    col[vga_x][vga_y] = int'(vga_colour);
                end
                if (abort_at >= 0 && n_plot == abort_at) return;
            end
            if (cyc == poke_at) begin
                start = 1'b1; mode = 2'd2; border_colour = 3'd1; fill_colour = 3'd1;
            end else begin
                start = 1'b0;
            end
`ifdef FRAME_PAINTER_STALL_EN
            if (do_stall && !stall_used && vga_plot && vga_x == 8'd40 && vga_y == 7'd20) begin
                vga_ready = 1'b0;
                stall_left = 3;
                stall_used = 1'b1;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) vga_ready = 1'b1;
            end
`else
            if (do_stall) stall_used = 1'b1;
`endif
            cyc++;
            @(negedge clk);
        end
        finished = (tail >= 10);
        check_eq("job_terminates", int'(finished), 1);
    endtask

    int sum_in;
    int n_wrong_col;

    initial begin
        rst_n = 1'b1; start = 1'b0; mode = 2'd0;
        border_colour = 3'd0; fill_colour = 3'd0;
`ifdef FRAME_PAINTER_STALL_EN
        vga_ready = 1'b1;
`endif
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_waitrequest", int'(waitrequest), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_plot", int'(vga_plot), 0);
        check_eq("rst_xy", int'(vga_x) + int'(vga_y), 0);
        check_eq("rst_colour", int'(vga_colour), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // a) FULL
        run_job(2'd0, 3'd7, 3'd0, -1, 1'b0, -1);
        check_eq("a_plots", n_plot, 19200);
        check_eq("a_distinct", n_distinct, 19200);
        check_eq("a_col_26_6", col[26][6], 7);
        check_eq("a_col_31_50", col[31][50], 7);
        check_eq("a_col_32_12", col[32][12], 0);
        check_eq("a_col_0_0", col[0][0], 0);
        check_eq("a_col_159_119", col[159][119], 0);
        check_eq("a_first", first_x * 1000 + first_y, 0);
        check_eq("a_done_after_last", done_px, 159119);
        check_eq("a_done_count", n_done, 1);
        check_eq("a_busy_cycles", n_wr, 19201);
        check_eq("a_colour_leak", n_leak, 0);

        // b) BORDER
        run_job(2'd1, 3'd5, 3'd3, -1, 1'b0, -1);
        check_eq("b_scan_cycles", n_wr - 1, 11664);
        check_eq("b_plots", n_plot, 2448);
        check_eq("b_first", first_x * 1000 + first_y, 26006);
        check_eq("b_last", last_x * 1000 + last_y, 133113);
        n_wrong_col = 0;
        sum_in = 0;
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++) begin
                if (cnt[i][j] != 0 && col[i][j] != 5) n_wrong_col++;
                if (i >= 32 && i <= 127 && j >= 12 && j <= 107) sum_in += cnt[i][j];
            end
        check_eq("b_colour", n_wrong_col, 0);
        check_eq("b_interior_plots", sum_in, 0);
        check_eq("b_colour_leak", n_leak, 0);
        check_eq("b_done_count", n_done, 1);

        // c) INTERIOR
        run_job(2'd2, 3'd6, 3'd2, -1, 1'b0, -1);
        check_eq("c_plots", n_plot, 9216);
        check_eq("c_first", first_x * 1000 + first_y, 32012);
        check_eq("c_last", last_x * 1000 + last_y, 127107);
        check_eq("c_second", px_x[1] * 1000 + px_y[1], 32013);
        check_eq("c_pixel97", px_x[96] * 1000 + px_y[96], 33012);
        n_wrong_col = 0;
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++)
                if (cnt[i][j] != 0 && col[i][j] != 2) n_wrong_col++;
        check_eq("c_colour", n_wrong_col, 0);
        check_eq("c_busy_cycles", n_wr, 9217);

        // d) start pulsed mid-job with new mode and colours
        run_job(2'd0, 3'd7, 3'd0, 300, 1'b0, -1);
        check_eq("d_plots", n_plot, 19200);
        check_eq("d_col_26_6", col[26][6], 7);
        check_eq("d_col_80_60", col[80][60], 0);
        check_eq("d_done_count", n_done, 1);
        check_eq("d_busy_cycles", n_wr, 19201);

        // e) reset mid-job
        run_job(2'd0, 3'd7, 3'd0, -1, 1'b0, 5000);
        check_eq("e_busy_before_rst", int'(waitrequest), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("e_rst_waitrequest", int'(waitrequest), 0);
        check_eq("e_rst_done", int'(done), 0);
        check_eq("e_rst_plot", int'(vga_plot), 0);
        check_eq("e_rst_xy", int'(vga_x) + int'(vga_y), 0);
        check_eq("e_rst_colour", int'(vga_colour), 0);
        n_done = 0;
        n_wr = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) n_done++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done) n_done++;
            if (waitrequest) n_wr++;
        end
        check_eq("e_no_done", n_done, 0);
        check_eq("e_no_resume", n_wr, 0);
        run_job(2'd0, 3'd7, 3'd0, -1, 1'b0, 2);
        check_eq("e_restart_first", px_x[0] * 1000 + px_y[0], 0);
        check_eq("e_restart_second", px_x[1] * 1000 + px_y[1], 1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef FRAME_PAINTER_STALL_EN
        // f) back-pressure on an INTERIOR job
        run_job(2'd2, 3'd0, 3'd2, -1, 1'b1, -1);
        check_eq("f_hold_40_20", cnt[40][20], 4);
        check_eq("f_plot_cycles", n_plot, 9219);
        check_eq("f_distinct", n_distinct, 9216);
        check_eq("f_job_len", n_wr - 1, 9219);
        check_eq("f_done_count", n_done, 1);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
